seven_segment_scan_ctrl: RTL and testbench
==========================================

# seven_segment_scan_ctrl

Avalon-MM slave that drives a multiplexed, common-anode, active-low seven-segment display of NUM_DIGITS digits from one clock domain. Software writes per-digit hex values and a control word; the block decodes hex to segment patterns and time-multiplexes them onto shared segment lines with digit-select strobes. It inserts a programmable blanking gap between digits to suppress ghosting. It sits on the HPS lightweight bridge in place of a single-digit PIO, and its pins go straight to the board display.

## Interface
- NUM_DIGITS, 4: number of digits scanned (1..8).
- SCAN_DIV, 50000: clk cycles each digit is driven per visit (≥1).
- BLANK_CYCLES, 500: clk cycles with all digits off between digits (≥1).
- BLINK_FRAMES, 64: full scan frames per blink half-period (compiled only with the blink feature).
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- address  in  3  word address.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data.
- readdata  out  32  read data, combinational from address, zero wait states.
- seg_n  out  7  segments g..a (bit0=a), active-low, registered.
- dp_n  out  1  decimal point, active-low, registered.
- dig_n  out  NUM_DIGITS  digit selects, active-low, one-hot-or-none, registered.

## Operation
- Register map:
  - 0..NUM_DIGITS-1 DIGITn: [3:0] hex value; [4] blank; [5] dp.
  - 4 CTRL: [0] enable; [1] raw mode, in which DIGITn[6:0] are driven as segments undecoded; bits [11:8] are read-only current digit index.
  - 5 BLINK_MASK: [NUM_DIGITS-1:0].
- Unmapped addresses read 0; writes to them are ignored. Unused read bits are 0.
- A write occurs when chipselect=1 and write_n=0. It is registered on that clock edge and is visible to reads and to the display from the next cycle.
- Decode is active-high internally, then inverted:
  - 0→3F, 1→06, 2→5B, 3→4F, 4→66, 5→6D, 6→7D, 7→07
  - 8→7F, 9→6F, A→77, b→7C, C→39, d→5E, E→79, F→71
  - On seg_n, 0 gives 7'h40, 8 gives 7'h00, and F gives 7'h0E.
- A digit's segments and dp are forced off when its blank bit=1, or when its blink mask bit=1 during the blink off-phase.
- State machine:
  - IDLE: all outputs off. Go to BLANK with idx=0 when enable=1.
  - BLANK: all digits off. Hold BLANK_CYCLES cycles, then go to DRIVE.
  - DRIVE: drive dig_n[idx]=0 with the decoded segments. Hold SCAN_DIV cycles, then advance idx (wrapping NUM_DIGITS-1→0) and go to BLANK.
  - In any state, enable=0 sends the FSM to IDLE on the next edge and resets idx to 0.
- The cycle counter width is clog2 of max(SCAN_DIV, BLANK_CYCLES).
- The frame counter increments on each idx wrap.

## Timing
- Reset values:
  - seg_n=7'h7F, dp_n=1, dig_n all 1s, readdata=0.
  - All registers 0; FSM in IDLE with idx=0.
  - Blink phase is "on" and the frame counter is 0.
- From the cycle after the enable write: BLANK_CYCLES cycles of BLANK, then digit 0 drives for exactly SCAN_DIV cycles.
- The frame period is NUM_DIGITS×(SCAN_DIV+BLANK_CYCLES) cycles.
- seg_n and dig_n change on the same edge. dig_n never has two zeros, and a digit never drives in a BLANK cycle.
- A DIGITn write during DRIVE of digit n updates seg_n 1 cycle after the write edge. The dwell time is not restarted.
- A CTRL write that keeps enable=1 does not disturb the scan position.
- Reset asserted mid-scan sets all outputs off immediately, asynchronously.
- Blink phase toggles when the frame counter reaches BLINK_FRAMES-1 at a wrap. The counter then clears.

## Configuration
- SEVEN_SEGMENT_BLINK_EN defined: BLINK_MASK register, frame counter and blink gating are present.
- SEVEN_SEGMENT_BLINK_EN undefined: address 5 reads 0 and writes are ignored. There is no frame counter, and digits are gated by their blank bit only.

## Structure
- Package seven_segment_pkg holds:
  - register address constants (ADDR_CTRL=4, ADDR_BLINK=5) and CTRL bit positions;
  - the FSM state enum {IDLE, BLANK, DRIVE};
  - the 16-entry hex-to-segment constant table.
- One sub-module, seven_segment_decoder: combinational, 4-bit value plus raw select to 7-bit active-high segments.

## Test plan
- Bench parameters: NUM_DIGITS=4, SCAN_DIV=4, BLANK_CYCLES=1, BLINK_FRAMES=2.
- Reset: all outputs off; CTRL reads 0. Write DIGIT0..3=0,8,F,1 and CTRL=1. Then dig_n cycles 1111,1110×4, 1111,1101×4, …, and seg_n shows 40,00,0E,79 in the matching DRIVE windows.
- Write DIGIT1=0x10 (blank) and DIGIT2=0x28 (dp, 8). Then digit1 drives seg_n=7F with dp_n=1, and digit2 drives seg_n=00 with dp_n=0.
- Write CTRL=0 mid-DRIVE of digit 2. The next cycle all outputs are off. Re-enable, and the scan restarts at BLANK then digit 0.
- Assert reset_n=0 mid-DRIVE. Outputs go off before the next clk edge. After release, all registers read 0.
- With blink built in, write BLINK_MASK=0x1. Digit 0 is dark for 2 frames and then lit for 2 frames, repeating, while digits 1–3 stay lit. Without the macro, BLINK_MASK reads 0.

Source files
------------

// File: rtl/seven_segment_pkg.sv
// seven_segment_pkg: shared constants for the multiplexed seven-segment
// display controller. Holds the register address map, CTRL bit positions,
// the scan FSM state type and the hex-to-segment table (active-high, bit0=a).
package seven_segment_pkg;

  localparam logic [2:0] ADDR_CTRL  = 3'd4;
  localparam logic [2:0] ADDR_BLINK = 3'd5;

  localparam int unsigned CTRL_ENABLE_BIT = 0;
  localparam int unsigned CTRL_RAW_BIT    = 1;
  localparam int unsigned CTRL_IDX_LSB    = 8;

  typedef enum logic [1:0] {
    IDLE,
    BLANK,
    DRIVE
  } scan_state_t;

  localparam logic [6:0] HEX_SEG_TABLE [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

endpackage

// File: rtl/seven_segment_decoder.sv
// seven_segment_decoder: combinational hex-to-segment decode.
// Ports:
//   value     in  4  hex digit to decode
//   raw_bits  in  7  segment pattern used verbatim in raw mode
//   raw_sel   in  1  1 = pass raw_bits through undecoded
//   seg       out 7  active-high segments g..a (bit0=a)
module seven_segment_decoder
  import seven_segment_pkg::*;
(
  input  logic [3:0] value,
  input  logic [6:0] raw_bits,
  input  logic       raw_sel,
  output logic [6:0] seg
);

  always_comb begin
    seg = HEX_SEG_TABLE[value];
    if (raw_sel) seg = raw_bits;
  end

endmodule

// File: rtl/seven_segment_scan_ctrl.sv
// seven_segment_scan_ctrl: Avalon-MM slave driving a multiplexed,
// common-anode, active-low seven-segment display. Each digit is visited
// for SCAN_DIV cycles, separated by BLANK_CYCLES of all-off to suppress
// ghosting.
// Optional feature macro: SEVEN_SEGMENT_BLINK_EN adds the BLINK_MASK
// register, the frame counter and blink gating.
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   address[2:0]        word address (DIGITn, CTRL=4, BLINK_MASK=5)
//   chipselect, write_n write strobe (write when cs=1, write_n=0)
//   writedata[31:0]     write data
//   readdata[31:0]      combinational read data, zero wait states
//   seg_n[6:0], dp_n    registered active-low segments / decimal point
//   dig_n[NUM_DIGITS-1:0] registered active-low digit selects
module seven_segment_scan_ctrl
  import seven_segment_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned SCAN_DIV     = 50000,
  parameter int unsigned BLANK_CYCLES = 500,
  parameter int unsigned BLINK_FRAMES = 64
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [2:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  output logic [6:0]            seg_n,
  output logic                  dp_n,
  output logic [NUM_DIGITS-1:0] dig_n
);

  localparam int unsigned CNT_MAX = (SCAN_DIV > BLANK_CYCLES) ? SCAN_DIV : BLANK_CYCLES;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int unsigned IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [6:0]            digit_reg [NUM_DIGITS];
  logic [1:0]            ctrl_reg;
  scan_state_t           state, state_nx;
  logic [IDX_W-1:0]      idx, idx_nx;
  logic [CNT_W-1:0]      cnt, cnt_nx;
  logic                  wrap;
  logic                  wr_en;
  logic                  digit_addr;
  logic [6:0]            cur_digit;
  logic [6:0]            seg_on;
  logic                  blink_gate;
  logic                  dark;
  logic [NUM_DIGITS-1:0] blink_rd;
  logic                  unused_wdata;

  assign wr_en        = chipselect & ~write_n;
  // Control addresses win over digit slots when NUM_DIGITS > 4.
  assign digit_addr   = (32'(address) < NUM_DIGITS) && (address != ADDR_CTRL) &&
                        (address != ADDR_BLINK);
  assign unused_wdata = ^writedata[31:7];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < NUM_DIGITS; i++) digit_reg[i] <= '0;
      ctrl_reg <= '0;
    end else if (wr_en) begin
      if (address == ADDR_CTRL) ctrl_reg <= writedata[1:0];
      for (int unsigned i = 0; i < NUM_DIGITS; i++)
        if (digit_addr && 32'(address) == i) digit_reg[i] <= writedata[6:0];
    end
  end

  // Scan FSM
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      idx   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      idx   <= idx_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    cnt_nx   = cnt;
    wrap     = 1'b0;
    if (!ctrl_reg[CTRL_ENABLE_BIT]) begin
      state_nx = IDLE;
      idx_nx   = '0;
      cnt_nx   = '0;
    end else begin
      case (state)
        IDLE: begin
          state_nx = BLANK;
          idx_nx   = '0;
          cnt_nx   = '0;
        end
        BLANK: begin
          if (cnt == CNT_W'(BLANK_CYCLES - 1)) begin
            state_nx = DRIVE;
            cnt_nx   = '0;
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
        DRIVE: begin
          if (cnt == CNT_W'(SCAN_DIV - 1)) begin
            state_nx = BLANK;
            cnt_nx   = '0;
            if (idx == IDX_W'(NUM_DIGITS - 1)) begin
              idx_nx = '0;
              wrap   = 1'b1;
            end else begin
              idx_nx = idx + 1'b1;
            end
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

`ifdef SEVEN_SEGMENT_BLINK_EN
  localparam int unsigned FRAME_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [NUM_DIGITS-1:0] blink_mask;
  logic [FRAME_W-1:0]    frame_cnt;
  logic                  blink_off;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blink_mask <= '0;
      frame_cnt  <= '0;
      blink_off  <= 1'b0;
    end else begin
      if (wr_en && address == ADDR_BLINK) blink_mask <= writedata[NUM_DIGITS-1:0];
      if (wrap) begin
        if (frame_cnt == FRAME_W'(BLINK_FRAMES - 1)) begin
          frame_cnt <= '0;
          blink_off <= ~blink_off;
        end else begin
          frame_cnt <= frame_cnt + 1'b1;
        end
      end
    end
  end

  assign blink_gate = blink_mask[idx_nx] & blink_off;
  assign blink_rd   = blink_mask;
`else
  localparam int unsigned unused_blink_frames = BLINK_FRAMES;
  logic unused_wrap;

  assign unused_wrap = wrap;
  assign blink_gate  = 1'b0;
  assign blink_rd    = '0;
`endif

  // Output data follows the next-state index so segments and digit select
  // land on the same edge, while register contents are taken as they stand
  // (a DIGIT write shows one edge after it is registered).
  assign cur_digit = digit_reg[idx_nx];
  assign dark      = cur_digit[4] | blink_gate;

  seven_segment_decoder u_decoder (
    .value   (cur_digit[3:0]),
    .raw_bits(cur_digit),
    .raw_sel (ctrl_reg[CTRL_RAW_BIT]),
    .seg     (seg_on)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      seg_n <= '1;
      dp_n  <= 1'b1;
      dig_n <= '1;
    end else if (state_nx == DRIVE) begin
      dig_n <= ~(NUM_DIGITS'(1) << idx_nx);
      seg_n <= dark ? '1 : ~seg_on;
      dp_n  <= dark | ~cur_digit[5];
    end else begin
      seg_n <= '1;
      dp_n  <= 1'b1;
      dig_n <= '1;
    end
  end

  always_comb begin
    readdata = '0;
    if (address == ADDR_CTRL) begin
      readdata[1:0]                    = ctrl_reg;
      readdata[CTRL_IDX_LSB +: IDX_W]  = idx;
    end else if (address == ADDR_BLINK) begin
      readdata[NUM_DIGITS-1:0] = blink_rd;
    end else begin
      for (int unsigned i = 0; i < NUM_DIGITS; i++)
        if (digit_addr && 32'(address) == i) readdata[6:0] = digit_reg[i];
    end
  end

endmodule

// File: tb/tb_seven_segment_scan_ctrl.sv
// Scoreboard bench for seven_segment_scan_ctrl. Expected display and read
// values are queued by the stimulus thread; a negedge monitor pops and
// compares them when their cycle comes up.
module tb_seven_segment_scan_ctrl;

  localparam int ND   = 4;
  localparam int SD   = 4;
  localparam int BC   = 1;
  localparam int BF   = 2;
  localparam int SLOT = SD + BC;
  localparam int P    = ND * SLOT;
  localparam logic [31:0] OFF_PAT = {20'b0, 4'hF, 7'h7F, 1'b1};
  localparam logic [6:0] HEX [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  logic          clk;
  logic          reset_n;
  logic [2:0]    address;
  logic          chipselect;
  logic          write_n;
  logic [31:0]   writedata;
  logic [31:0]   readdata;
  logic [6:0]    seg_n;
  logic          dp_n;
  logic [ND-1:0] dig_n;

  seven_segment_scan_ctrl #(
    .NUM_DIGITS  (ND),
    .SCAN_DIV    (SD),
    .BLANK_CYCLES(BC),
    .BLINK_FRAMES(BF)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .readdata  (readdata),
    .seg_n     (seg_n),
    .dp_n      (dp_n),
    .dig_n     (dig_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    bit          is_rd;
    logic [31:0] exp;
    string       name;
  } sb_t;

  sb_t sbq[$];
  int  n_err = 0;
  int  n_chk = 0;

  logic [6:0]    m_dig [ND];
  logic [1:0]    m_ctrl;
  logic [ND-1:0] m_mask;

  function automatic void push(int c, bit rd, logic [31:0] e, string nm);
    sb_t s;
    s.cyc = c; s.is_rd = rd; s.exp = e; s.name = nm;
    sbq.push_back(s);
  endfunction

  // Display expected t cycles after scanning starts (t=0 is the first BLANK).
  function automatic logic [11:0] model_out(int t);
    int f, w, d, p;
    logic [6:0] v, on;
    logic [3:0] dg;
    bit dark;
    f = t / P; w = t % P; d = w / SLOT; p = w % SLOT;
    if (p < BC) return OFF_PAT[11:0];
    v    = m_dig[d];
    on   = m_ctrl[1] ? v : HEX[v[3:0]];
    dark = v[4] || (m_mask[d] && ((f / BF) % 2 == 1));
    dg   = '1;
    dg[d] = 1'b0;
    return {dg, dark ? 7'h7F : ~on, dark ? 1'b1 : ~v[5]};
  endfunction

  function automatic void push_scan(int t0, int ts, int te);
    for (int t = ts; t < te; t++) push(t0 + t, 1'b0, 32'(model_out(t)), $sformatf("scan t=%0d", t));
  endfunction

  function automatic void clear_mirror();
    for (int i = 0; i < ND; i++) m_dig[i] = '0;
    m_ctrl = '0;
    m_mask = '0;
  endfunction

  task automatic wait_cyc(int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus_write(logic [2:0] a, logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(posedge clk);
    #1;
    chipselect = 1'b0; write_n = 1'b1;
    if (a == 3'd4) m_ctrl = d[1:0];
    else if (a == 3'd5) begin
`ifdef SEVEN_SEGMENT_BLINK_EN
      m_mask = d[ND-1:0];
`endif
    end else if (32'(a) < ND) m_dig[a] = d[6:0];
  endtask

  task automatic bus_read(logic [2:0] a, logic [31:0] e, string nm);
    address = a; chipselect = 1'b1; write_n = 1'b1;
    push(cyc, 1'b1, e, nm);
    @(posedge clk);
    #1;
    chipselect = 1'b0;
  endtask

  always @(negedge clk) begin
    logic [31:0] act;
    for (int i = sbq.size() - 1; i >= 0; i--) begin
      if (sbq[i].cyc <= cyc) begin
        act = sbq[i].is_rd ? readdata : {20'b0, dig_n, seg_n, dp_n};
        n_chk++;
        if (sbq[i].cyc < cyc) begin
          n_err++;
          $display("FAIL %s: sample for cycle %0d missed (now %0d), required %h", sbq[i].name,
                   sbq[i].cyc, cyc, sbq[i].exp);
        end else if (act !== sbq[i].exp) begin
          n_err++;
          $display("FAIL %s @cyc %0d: got %h required %h", sbq[i].name, cyc, act, sbq[i].exp);
        end
        sbq.delete(i);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, required bench completion");
    $fatal(1);
  end

  initial begin
    int t0, w, raw, tr;
    logic [31:0] v;
    logic [1:0]  ctrl;

    reset_n = 1'b0; address = '0; chipselect = 1'b0; write_n = 1'b1; writedata = '0;
    clear_mirror();
    repeat (2) @(posedge clk);
    #1;
    push(cyc, 1'b0, OFF_PAT, "in reset outputs");
    @(negedge clk);
    #2 reset_n = 1'b1;
    @(posedge clk);
    #1;
    push(cyc, 1'b0, OFF_PAT, "post reset outputs");
    for (int a = 0; a < 8; a++) bus_read(3'(a), 32'h0, $sformatf("reset read a=%0d", a));

    // Basic scan: 0,8,F,1
    bus_write(3'd0, 32'h0); bus_write(3'd1, 32'h8);
    bus_write(3'd2, 32'hF); bus_write(3'd3, 32'h1);
    bus_write(3'd4, 32'h1);
    w = cyc;
    push(w, 1'b0, OFF_PAT, "idle at enable edge");
    t0 = w + 1;
    push_scan(t0, 0, 40);
    tr = $urandom_range(0, 38);
    wait_cyc(t0 + tr);
    bus_read(3'd4, 32'h1 | (32'((tr % P) / SLOT) << 8), "ctrl idx during scan");

    // Blank digit 1, dp + 8 on digit 2, written mid-scan
    wait_cyc(t0 + 39);
    bus_write(3'd1, 32'h10);
    bus_write(3'd2, 32'h28);
    push_scan(t0, 42, 73);

    // Disable mid-DRIVE of digit 2 (t=72)
    wait_cyc(t0 + 71);
    bus_write(3'd4, 32'h0);
    for (int k = 1; k <= 3; k++) push(cyc + k, 1'b0, OFF_PAT, "off after disable");
    wait_cyc(t0 + 74);
    bus_read(3'd4, 32'h0, "ctrl after disable");

    // Re-enable with random contents, maybe raw mode
    wait_cyc(t0 + 76);
    raw = int'($urandom_range(0, 1));
    for (int i = 0; i < ND; i++) begin
      v = $urandom;
      v = raw != 0 ? (v & 32'h4F) : (v & 32'h3F);
      if (i == 1) v = v & ~32'h10;
      bus_write(3'(i), v);
    end
    bus_write(3'd6, $urandom);
    bus_write(3'd7, $urandom);
    bus_read(3'd6, 32'h0, "unmapped read 6");
    bus_read(3'd7, 32'h0, "unmapped read 7");
    ctrl = {raw[0], 1'b1};
    bus_write(3'd4, 32'(ctrl));
    w = cyc;
    push(w, 1'b0, OFF_PAT, "idle at re-enable edge");
    t0 = w + 1;
    push_scan(t0, 0, 28);
    wait_cyc(t0 + 13);
    bus_read(3'd4, 32'h200 | 32'(ctrl), "ctrl idx digit2");
    for (int i = 0; i < ND; i++) bus_read(3'(i), 32'(m_dig[i]), $sformatf("digit%0d readback", i));

    // Asynchronous reset mid-DRIVE of digit 1 (t=28)
    wait_cyc(t0 + 27);
    @(posedge clk);
    #2 reset_n = 1'b0;
    push(cyc, 1'b0, OFF_PAT, "async reset mid-drive");
    @(posedge clk);
    #1;
    push(cyc, 1'b0, OFF_PAT, "held in reset");
    @(negedge clk);
    #2 reset_n = 1'b1;
    clear_mirror();
    @(posedge clk);
    #1;
    for (int a = 0; a < 8; a++) bus_read(3'(a), 32'h0, $sformatf("after reset read a=%0d", a));

    // Blink on digit 0
    for (int i = 0; i < ND; i++) bus_write(3'(i), $urandom & 32'h2F);
    bus_write(3'd5, 32'h1);
    bus_read(3'd5, 32'(m_mask), "blink mask read");
    bus_write(3'd4, 32'h1);
    w = cyc;
    push(w, 1'b0, OFF_PAT, "idle before blink scan");
    t0 = w + 1;
    push_scan(t0, 0, 5 * P);
    wait_cyc(t0 + 5 * P + 2);

    if (sbq.size() != 0) begin
      n_chk++;
      n_err++;
      $display("FAIL drain: %0d expectations left, required 0", sbq.size());
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
